// File: rtl/bt_score_tx.sv
// bt_score_tx: UART (8N1, LSB first) transmitter that reports score and miss
// to the Bluetooth module as a packet: HEADER, {4'h0,score}, {4'h0,miss}.
// Optional build macro BT_SCORE_TX_CHECKSUM_EN appends a fourth byte,
// HEADER ^ score byte ^ miss byte. Without it no checksum logic exists.
// A packet is launched by a send_req pulse or by any change of (score, miss)
// against the last reported pair. A trigger while a packet is on the line is
// remembered (one deep) and produces a follow-up packet with no idle gap.
module bt_score_tx #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 9600,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score,
  input  logic [3:0] miss,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef BT_SCORE_TX_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic             pending;
  logic [3:0]       last_score;
  logic [3:0]       last_miss;
  logic [3:0]       score_snap;
  logic [3:0]       miss_snap;

  logic             trigger;
  logic             at_bit_end;
  logic             pkt_end;
  logic             relaunch;
  logic             load_snap;
  logic [7:0]       cur_byte;

  // Byte of the packet selected by its position; only the snapshots are used.
  function automatic logic [7:0] pkt_byte(input logic [1:0] idx,
                                          input logic [3:0] s,
                                          input logic [3:0] m);
    case (idx)
      2'd0:    pkt_byte = HEADER;
      2'd1:    pkt_byte = {4'h0, s};
      2'd2:    pkt_byte = {4'h0, m};
`ifdef BT_SCORE_TX_CHECKSUM_EN
      default: pkt_byte = HEADER ^ {4'h0, s} ^ {4'h0, m};
`else
      default: pkt_byte = 8'hFF;
`endif
    endcase
  endfunction

  assign trigger    = send_req || (score != last_score) || (miss != last_miss);
  assign at_bit_end = (baud_cnt == CNT_LAST);
  assign pkt_end    = (state == S_STOP) && at_bit_end && (byte_idx == BYTE_LAST);
  // A trigger landing on the very last stop-bit cycle counts as pending.
  assign relaunch   = pkt_end && (pending || trigger);
  assign load_snap  = ((state == S_IDLE) && trigger) || relaunch;
  assign cur_byte   = pkt_byte(byte_idx, score_snap, miss_snap);

  // Packet payload snapshot; data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_snap) begin
      score_snap <= score;
      miss_snap  <= miss;
    end
  end

  // Transmit FSM: bit timing, byte sequencing, pending merge and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      pending    <= 1'b0;
      last_score <= 4'h0;
      last_miss  <= 4'h0;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
    end else begin
      pkt_done <= 1'b0;
      if ((state != S_IDLE) && trigger) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state      <= S_START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 2'd0;
            last_score <= score;
            last_miss  <= miss;
          end
        end
        S_START: begin
          if (at_bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= S_DATA;
            tx       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (at_bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              tx <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (at_bit_end) begin
            baud_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= S_START;
              tx       <= 1'b0;
            end else begin
              byte_idx <= 2'd0;
              pkt_done <= 1'b1;
              if (relaunch) begin
                pending    <= 1'b0;
                state      <= S_START;
                tx         <= 1'b0;
                last_score <= score;
                last_miss  <= miss;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_score_tx.sv
// Bench for bt_score_tx with CLK_FREQ=16, BAUD=1 (16 cycles per bit).
// The reference model derives the expected tx waveform of a packet directly
// from the framing rules (start 0, 8 data bits LSB first, stop 1, bytes
// back-to-back) and compares it cycle by cycle against the sampled line.
module tb_bt_score_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef BT_SCORE_TX_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int PKT_CYC = NB * 10 * DIV;
  localparam int REC_MAX = 2 * PKT_CYC + 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] score;
  logic [3:0] miss;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       pkt_done;

  int errors = 0;
  int checks = 0;

  bit txw   [REC_MAX];
  bit busyw [REC_MAX];
  bit donew [REC_MAX];

  logic [3:0] last_s;
  logic [3:0] last_m;

  bt_score_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .HEADER  (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .score   (score),
    .miss    (miss),
    .send_req(send_req),
    .tx      (tx),
    .busy    (busy),
    .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  // Packet bytes packed LSB-first: byte0 = header, byte1 = score, byte2 = miss, byte3 = checksum.
  function automatic logic [31:0] make_pkt(input logic [3:0] s, input logic [3:0] m);
    logic [7:0] c;
    c = 8'hA5 ^ {4'h0, s} ^ {4'h0, m};
    return {c, 4'h0, m, 4'h0, s, 8'hA5};
  endfunction

  // Expected line level k cycles after the start of a packet.
  function automatic logic exp_tx(input logic [31:0] p, input int k);
    int byt;
    int bitn;
    logic [31:0] sh;
    byt  = k / (10 * DIV);
    bitn = (k / DIV) % 10;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    sh = p >> (byt * 8 + bitn - 1);
    return sh[0];
  endfunction

  // Capture n consecutive cycles of DUT outputs, sampled on the falling edge.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txw[i]   = tx;
      busyw[i] = busy;
      donew[i] = pkt_done;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; score = 4'h0; miss = 4'h0; send_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    last_s = 4'h0;
    last_m = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; score = 4'h0; miss = 4'h0; send_req = 1'b0;
    last_s = 4'h0; last_m = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", pkt_done); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad_tx;
    int bad_busy;
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL idle_tx: %0d cycles not high, want 0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL idle_busy: %0d busy cycles, want 0", bad_busy); end
  endtask

  task automatic test_single();
    logic [31:0] p;
    int mism, first, bcnt, dcnt;
    p = make_pkt(4'd3, 4'd1);
    @(posedge clk);
    #1 score = 4'd3; miss = 4'd1; send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    last_s = 4'd3; last_m = 4'd1;
    record(PKT_CYC + 2);
    mism = 0; first = -1; bcnt = 0; dcnt = 0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (txw[k] !== exp_tx(p, k)) begin mism++; if (first < 0) first = k; end
      if (busyw[k]) bcnt++;
      if (donew[k]) dcnt++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL single_wave: %0d cycles differ (first at %0d), want 0", mism, first); end
    checks++;
    if (bcnt != PKT_CYC) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", bcnt, PKT_CYC); end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL single_done_early: got %0d pulses want 0", dcnt); end
    checks++;
    if (busyw[PKT_CYC] !== 1'b0 || donew[PKT_CYC] !== 1'b1 || txw[PKT_CYC] !== 1'b1)
      begin errors++; $display("FAIL single_end: busy=%b done=%b tx=%b want 0 1 1", busyw[PKT_CYC], donew[PKT_CYC], txw[PKT_CYC]); end
    checks++;
    if (donew[PKT_CYC+1] !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", donew[PKT_CYC+1]); end
  endtask

  task automatic test_change();
    logic [31:0] p;
    int mism, first, bcnt;
    do_reset();
    repeat (5) @(posedge clk);
    p = make_pkt(4'd5, 4'd0);
    #1 score = 4'd5;
    last_s = 4'd5; last_m = 4'd0;
    @(posedge clk);
    record(PKT_CYC + 1);
    mism = 0; first = -1; bcnt = 0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (txw[k] !== exp_tx(p, k)) begin mism++; if (first < 0) first = k; end
      if (busyw[k]) bcnt++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL change_wave: %0d cycles differ (first at %0d), want 0", mism, first); end
    checks++;
    if (bcnt != PKT_CYC) begin errors++; $display("FAIL change_busy_len: got %0d want %0d", bcnt, PKT_CYC); end
    checks++;
    if (donew[PKT_CYC] !== 1'b1) begin errors++; $display("FAIL change_done: got %b want 1", donew[PKT_CYC]); end
    bcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bcnt++;
    end
    checks++;
    if (bcnt != 0) begin errors++; $display("FAIL change_hold_quiet: %0d busy cycles want 0", bcnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p1, p2;
    int m1, m2, bcnt, dcnt;
    p1 = make_pkt(4'd5, 4'd0);
    p2 = make_pkt(4'd5, 4'd2);
    @(posedge clk);
    #1 send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    fork
      record(2 * PKT_CYC + 1);
      begin
        repeat (100) @(posedge clk);
        #1 miss = 4'd2;
        repeat (30) @(posedge clk);
        #1 send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
        repeat (40) @(posedge clk);
        #1 send_req = 1'b1;
        @(posedge clk);
        #1 send_req = 1'b0;
      end
    join
    last_s = 4'd5; last_m = 4'd2;
    m1 = 0; m2 = 0; bcnt = 0; dcnt = 0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (txw[k] !== exp_tx(p1, k)) m1++;
      if (txw[PKT_CYC + k] !== exp_tx(p2, k)) m2++;
    end
    for (int k = 0; k < 2 * PKT_CYC; k++) begin
      if (busyw[k]) bcnt++;
      if (donew[k]) dcnt++;
    end
    checks++;
    if (m1 != 0) begin errors++; $display("FAIL b2b_first_wave: %0d cycles differ want 0", m1); end
    checks++;
    if (m2 != 0) begin errors++; $display("FAIL b2b_second_wave: %0d cycles differ want 0", m2); end
    checks++;
    if (bcnt != 2 * PKT_CYC) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", bcnt, 2 * PKT_CYC); end
    checks++;
    if (dcnt != 1 || donew[PKT_CYC] !== 1'b1) begin errors++; $display("FAIL b2b_mid_done: pulses=%0d at_boundary=%b want 1 1", dcnt, donew[PKT_CYC]); end
    checks++;
    if (busyw[2*PKT_CYC] !== 1'b0 || donew[2*PKT_CYC] !== 1'b1)
      begin errors++; $display("FAIL b2b_end: busy=%b done=%b want 0 1", busyw[2*PKT_CYC], donew[2*PKT_CYC]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p1, p2;
    int cut, mism, bcnt;
    p1  = make_pkt(4'd5, 4'd2);
    p2  = make_pkt(4'd5, 4'd0);
    cut = 2 * 10 * DIV + 4 * DIV + 5;
    @(posedge clk);
    #1 send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    record(cut + 1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    mism = 0;
    for (int k = 0; k <= cut; k++) if (txw[k] !== exp_tx(p1, k)) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rstmid_prefix: %0d cycles differ want 0", mism); end
    repeat (3) @(posedge clk);
    #1 score = 4'd5; miss = 4'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    last_s = 4'd5; last_m = 4'd0;
    @(posedge clk);
    record(PKT_CYC + 1);
    mism = 0; bcnt = 0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (txw[k] !== exp_tx(p2, k)) mism++;
      if (busyw[k]) bcnt++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rstmid_fresh_wave: %0d cycles differ want 0", mism); end
    checks++;
    if (bcnt != PKT_CYC || busyw[PKT_CYC] !== 1'b0) begin errors++; $display("FAIL rstmid_fresh_busy: got %0d want %0d", bcnt, PKT_CYC); end
  endtask

  task automatic test_wrap();
    logic [31:0] p;
    int mism;
    @(posedge clk);
    #1 score = 4'd15; miss = 4'd3; send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    record(PKT_CYC + 1);
    #1 score = 4'd0;
    p = make_pkt(4'd0, 4'd3);
    last_s = 4'd0; last_m = 4'd3;
    @(posedge clk);
    record(PKT_CYC + 1);
    mism = 0;
    for (int k = 0; k < PKT_CYC; k++) if (txw[k] !== exp_tx(p, k)) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL wrap_wave: %0d cycles differ want 0", mism); end
    checks++;
    if (donew[PKT_CYC] !== 1'b1 || busyw[PKT_CYC] !== 1'b0) begin errors++; $display("FAIL wrap_end: done=%b busy=%b want 1 0", donew[PKT_CYC], busyw[PKT_CYC]); end
  endtask

  task automatic test_random();
    logic [3:0] ns, nm;
    logic [31:0] p;
    int mode, mism, stop_bad, bcnt, quiet;
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 2);
      ns   = 4'($urandom_range(0, 15));
      nm   = 4'($urandom_range(0, 15));
      if (mode == 1 && ns == last_s && nm == last_m) ns = last_s + 4'd1;
      p = make_pkt(ns, nm);
      @(posedge clk);
      #1 score = ns; miss = nm; send_req = (mode != 1);
      @(posedge clk);
      #1 send_req = 1'b0;
      last_s = ns; last_m = nm;
      record(PKT_CYC + 1);
      mism = 0; stop_bad = 0; bcnt = 0;
      for (int k = 0; k < PKT_CYC; k++) begin
        if (txw[k] !== exp_tx(p, k)) mism++;
        if (((k / DIV) % 10) == 9 && txw[k] !== 1'b1) stop_bad++;
        if (busyw[k]) bcnt++;
      end
      checks++;
      if (mism != 0) begin errors++; $display("FAIL rand%0d_wave: mode=%0d s=%0d m=%0d %0d cycles differ want 0", it, mode, ns, nm, mism); end
      checks++;
      if (stop_bad != 0) begin errors++; $display("FAIL rand%0d_stop: %0d stop cycles low want 0", it, stop_bad); end
      checks++;
      if (bcnt != PKT_CYC) begin errors++; $display("FAIL rand%0d_busy_len: got %0d want %0d", it, bcnt, PKT_CYC); end
      checks++;
      if (donew[PKT_CYC] !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %b want 1", it, donew[PKT_CYC]); end
      quiet = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (busy !== 1'b0) quiet++;
      end
      checks++;
      if (quiet != 0) begin errors++; $display("FAIL rand%0d_single_pkt: %0d busy cycles after packet want 0", it, quiet); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_change();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
